// File: rtl/spi_queued_cu_pkg.sv
// Shared definitions for the queued SPI control unit: dispatch states,
// register indices and control/status bit positions.
package spi_queued_cu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    localparam int REG_CONTROL      = 0;
    localparam int REG_DELAY        = 1;
    localparam int REG_PERIOD       = 2;
    localparam int REG_TRIGGER      = 3;
    localparam int REG_COUNTER      = 4;
    localparam int REG_CHANNEL_BASE = 5;

    localparam int CTRL_SPI_MODE       = 0;
    localparam int CTRL_DIVIDER_LSB    = 1;
    localparam int CTRL_LENGTH_LSB     = 4;
    localparam int CTRL_DIRECTION      = 9;
    localparam int CTRL_START_GEN      = 12;
    localparam int CTRL_SS_POLARITY    = 13;
    localparam int CTRL_SS_DELAY       = 14;
    localparam int CTRL_LENGTH_CHOICE  = 15;
    localparam int CTRL_LATCHING_EDGE  = 16;
    localparam int CTRL_CLOCK_POLARITY = 17;

    localparam int STATUS_BUSY      = 0;
    localparam int STATUS_OVERRUN   = 1;
    localparam int STATUS_LEVEL_LSB = 16;

    function automatic logic [31:0] control_reset_value(input logic ss_default);
        logic [31:0] value;
        value = '0;
        value[CTRL_LENGTH_LSB +: 4]  = 4'hE;
        value[CTRL_SS_POLARITY]      = ss_default;
        value[CTRL_CLOCK_POLARITY]   = ss_default;
        return value;
    endfunction

endpackage

// File: rtl/spi_transfer_queue.sv
// Synchronous FIFO holding packed stream transfers; exposes its fill level
// so the control unit can report it in the status register.
module spi_transfer_queue #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (level == (AW+1)'(DEPTH));
    assign empty   = (level == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Concurrent push and pop cancel out in the level.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spi_queued_cu.sv
// SPI control unit: AXI-lite register file plus a dispatch FSM that launches
// transfers from bus triggers or from the stream-fed transfer queue.
module spi_queued_cu #(
    parameter int N_CHANNELS          = 3,
    parameter int DATA_WIDTH          = 32,
    parameter int QUEUE_DEPTH         = 8,
    parameter bit SS_POLARITY_DEFAULT = 1'b0
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] spi_data_in,
    input  logic                                  transfer_done,
    output logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] spi_data_out,
    output logic                                  spi_mode,
    output logic [2:0]                            divider_setting,
    output logic [3:0]                            spi_transfer_length,
    output logic                                  spi_direction,
    output logic                                  start_generator_enable,
    output logic                                  ss_polarity,
    output logic                                  ss_deassert_delay_enable,
    output logic                                  transfer_length_choice,
    output logic                                  latching_edge,
    output logic                                  clock_polarity,
    output logic [31:0]                           spi_delay,
    output logic [31:0]                           period,
    output logic                                  spi_start_transfer,
    input  logic [7:0]                            axi_in_awaddr,
    input  logic                                  axi_in_awvalid,
    output logic                                  axi_in_awready,
    input  logic [31:0]                           axi_in_wdata,
    input  logic                                  axi_in_wvalid,
    output logic                                  axi_in_wready,
    output logic [1:0]                            axi_in_bresp,
    output logic                                  axi_in_bvalid,
    input  logic                                  axi_in_bready,
    input  logic [7:0]                            axi_in_araddr,
    input  logic                                  axi_in_arvalid,
    output logic                                  axi_in_arready,
    output logic [31:0]                           axi_in_rdata,
    output logic [1:0]                            axi_in_rresp,
    output logic                                  axi_in_rvalid,
    input  logic                                  axi_in_rready,
    input  logic                                  external_spi_transfer_valid,
    output logic                                  external_spi_transfer_ready,
    input  logic [N_CHANNELS*DATA_WIDTH-1:0]      external_spi_transfer_data
);
    import spi_queued_cu_pkg::*;

    localparam int PW = N_CHANNELS * DATA_WIDTH;
    localparam int LW = $clog2(QUEUE_DEPTH) + 1;

    state_t                                state;
    logic [31:0]                           control;
    logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] channel_words;
    logic [31:0]                           counter;
    logic                                  overrun;
    logic                                  ready_en;
    logic [LW-1:0]                         queue_level;
    logic                                  queue_full;
    logic                                  queue_empty;
    logic [PW-1:0]                         queue_head;
    logic                                  wr_fire;
    logic                                  rd_fire;
    logic [5:0]                            wr_index;
    logic [5:0]                            rd_index;
    logic                                  bus_trigger;
    logic                                  push;
    logic                                  pop;
    logic                                  busy;
    logic [31:0]                           read_value;
    logic                                  unused_addr;

    assign wr_index       = axi_in_awaddr[7:2];
    assign rd_index       = axi_in_araddr[7:2];
    assign unused_addr    = ^{axi_in_awaddr[1:0], axi_in_araddr[1:0]};
    assign wr_fire        = axi_in_awvalid && axi_in_wvalid && !axi_in_bvalid;
    assign rd_fire        = axi_in_arvalid && !axi_in_rvalid;
    assign axi_in_awready = !axi_in_bvalid;
    assign axi_in_wready  = !axi_in_bvalid;
    assign axi_in_arready = !axi_in_rvalid;
    assign axi_in_bresp   = 2'b00;
    assign axi_in_rresp   = 2'b00;

    assign bus_trigger = wr_fire && (wr_index == 6'(REG_TRIGGER));
    assign external_spi_transfer_ready = ready_en && !queue_full;
    assign push = external_spi_transfer_valid && external_spi_transfer_ready;
    // A bus trigger wins the IDLE slot, so the queue head is left in place.
    assign pop  = (state == ST_IDLE) && !bus_trigger && !queue_empty;
    assign busy = (state != ST_IDLE) || !queue_empty;

    assign spi_mode                 = control[CTRL_SPI_MODE];
    assign divider_setting          = control[CTRL_DIVIDER_LSB +: 3];
    assign spi_transfer_length      = control[CTRL_LENGTH_LSB +: 4];
    assign spi_direction            = control[CTRL_DIRECTION];
    assign start_generator_enable   = control[CTRL_START_GEN];
    assign ss_polarity              = control[CTRL_SS_POLARITY];
    assign ss_deassert_delay_enable = control[CTRL_SS_DELAY];
    assign transfer_length_choice   = control[CTRL_LENGTH_CHOICE];
    assign latching_edge            = control[CTRL_LATCHING_EDGE];
    assign clock_polarity           = control[CTRL_CLOCK_POLARITY];

    spi_transfer_queue #(
        .WIDTH (PW),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (external_spi_transfer_data),
        .pop       (pop),
        .head      (queue_head),
        .full      (queue_full),
        .empty     (queue_empty),
        .level     (queue_level)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            control       <= control_reset_value(SS_POLARITY_DEFAULT);
            spi_delay     <= '0;
            period        <= 32'd1;
            channel_words <= '0;
            counter       <= '0;
            overrun       <= 1'b0;
            ready_en      <= 1'b0;
            axi_in_bvalid <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (wr_fire) axi_in_bvalid <= 1'b1;
            else if (axi_in_bready) axi_in_bvalid <= 1'b0;
            if (wr_fire) begin
                case (wr_index)
                    6'(REG_CONTROL): control   <= axi_in_wdata;
                    6'(REG_DELAY):   spi_delay <= axi_in_wdata;
                    6'(REG_PERIOD):  period    <= axi_in_wdata;
                    default: ;
                endcase
                for (int i = 0; i < N_CHANNELS; i++) begin
                    if (wr_index == 6'(REG_CHANNEL_BASE + i))
                        channel_words[i] <= axi_in_wdata[DATA_WIDTH-1:0];
                end
            end
            if (wr_fire && (wr_index == 6'(REG_COUNTER))) counter <= '0;
            else if ((state == ST_WAIT_DONE) && transfer_done) counter <= counter + 32'd1;
            overrun <= (overrun && !(bus_trigger && axi_in_wdata[STATUS_OVERRUN]))
                     || (bus_trigger && (state != ST_IDLE));
        end
    end

    always_comb begin
        read_value = '0;
        case (rd_index)
            6'(REG_CONTROL): read_value = control;
            6'(REG_DELAY):   read_value = spi_delay;
            6'(REG_PERIOD):  read_value = period;
            6'(REG_TRIGGER): begin
                read_value[STATUS_LEVEL_LSB +: 8] = 8'(queue_level);
                read_value[STATUS_OVERRUN]        = overrun;
                read_value[STATUS_BUSY]           = busy;
            end
            6'(REG_COUNTER): read_value = counter;
            default: ;
        endcase
        for (int i = 0; i < N_CHANNELS; i++) begin
            if (rd_index == 6'(REG_CHANNEL_BASE + i))
                read_value[DATA_WIDTH-1:0] = spi_data_in[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            axi_in_rdata  <= '0;
            axi_in_rvalid <= 1'b0;
        end else if (rd_fire) begin
            axi_in_rdata  <= read_value;
            axi_in_rvalid <= 1'b1;
        end else if (axi_in_rready) begin
            axi_in_rvalid <= 1'b0;
        end
    end

    // Transmit words are latched on entry to START and held until the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state              <= ST_IDLE;
            spi_start_transfer <= 1'b0;
            spi_data_out       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus_trigger) begin
                        state              <= ST_START;
                        spi_start_transfer <= 1'b1;
                        spi_data_out       <= channel_words;
                    end else if (!queue_empty) begin
                        state              <= ST_START;
                        spi_start_transfer <= 1'b1;
                        spi_data_out       <= queue_head;
                    end
                end
                ST_START: begin
                    state              <= ST_WAIT_DONE;
                    spi_start_transfer <= 1'b0;
                end
                ST_WAIT_DONE: begin
                    if (transfer_done) state <= ST_IDLE;
                end
                default: begin
                    state              <= ST_IDLE;
                    spi_start_transfer <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/spi_queued_cu.md
SPI_QUEUED_CU -- requirements
Module: spi_queued_cu

Interface
REQ-001 SHALL take parameter N_CHANNELS, default 3: number of SPI data channels, 1..8.
REQ-002 SHALL take parameter DATA_WIDTH, default 32: per-channel word width, 8..32.
REQ-003 SHALL take parameter QUEUE_DEPTH, default 8: stream transfer queue entries, power of two, 2..64.
REQ-004 SHALL take parameter SS_POLARITY_DEFAULT, default 0: reset value of the ss_polarity and clock_polarity bits.
REQ-005 SHALL have port clock  in  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port spi_data_in  in  [N_CHANNELS][DATA_WIDTH]  received words from the SPI engine.
REQ-008 SHALL have port transfer_done  in  1  single-cycle pulse from the engine at transfer end.
REQ-009 SHALL have port spi_data_out  out  [N_CHANNELS][DATA_WIDTH]  words to transmit.
REQ-010 SHALL have ports spi_mode, divider_setting[2:0], spi_transfer_length[3:0], spi_direction, start_generator_enable, ss_polarity, ss_deassert_delay_enable, transfer_length_choice, latching_edge, clock_polarity  out: control register 0 bits 0, 3:1, 7:4, 9, 12, 13, 14, 15, 16, 17.
REQ-011 SHALL have ports spi_delay[31:0] and period[31:0]  out: registers 1 and 2.
REQ-012 SHALL have port spi_start_transfer  out  1  single-cycle transfer start.
REQ-013 SHALL have port axi_in  axi_lite.slave  register access, register i at byte offset 4*i.
REQ-014 SHALL have port external_spi_transfer  axi_stream.slave  queued transfers; data carries N_CHANNELS words packed, channel 0 in LSBs.

Function
REQ-015 Register map: 0 control, 1 delay, 2 period, 3 trigger (write)/status (read), 4 transfer counter, 5..4+N_CHANNELS channel words; unmapped reads return 0.
REQ-016 Status read SHALL be {queue_level in [23:16], overrun in [1], busy in [0]}; writing bit1=1 to register 3 clears overrun, any write to register 3 is a bus trigger.
REQ-017 Register 4 SHALL count completed transfers (transfer_done in WAIT_DONE), wrapping at 2^32; any write clears it, the clear taking priority over a same-cycle increment.
REQ-018 external_spi_transfer.ready SHALL equal not-queue-full; a beat is pushed when valid and ready.
REQ-019 Dispatch FSM states IDLE, START, WAIT_DONE; IDLE->START on bus trigger or non-empty queue; START->WAIT_DONE unconditionally; WAIT_DONE->IDLE on transfer_done.
REQ-020 spi_start_transfer SHALL be high exactly during START.
REQ-021 Bus trigger and non-empty queue in the same IDLE cycle: bus wins; queue entry stays.
REQ-022 Queue-sourced transfer: entry popped on IDLE->START and latched; spi_data_out driven from latch until next START; bus transfer drives spi_data_out from registers 5..
REQ-023 Beat accepted into empty queue at cycle N with FSM IDLE: spi_start_transfer high at N+2.
REQ-024 Bus trigger while not IDLE SHALL be discarded and set overrun.
REQ-025 transfer_done outside WAIT_DONE SHALL be ignored.
REQ-026 Simultaneous push and pop SHALL leave queue_level unchanged.
REQ-027 busy SHALL be high whenever FSM is not IDLE or queue is non-empty.
REQ-028 Register 5+i read SHALL return spi_data_in[i], zero-extended to 32 bits.

Reset
REQ-029 Asserting reset SHALL asynchronously force FSM IDLE, queue empty, counter 0, overrun 0, spi_start_transfer 0, ready 0 while asserted and 1 on the first clock after release.
REQ-030 Reset values: control = SS_POLARITY_DEFAULT in bits 17 and 13, 4'hE in bits 7:4, else 0; delay 0; period 1; channel words 0; spi_data_out 0.
REQ-031 Reset during WAIT_DONE SHALL drop the transfer without counting it.

Structure
REQ-032 Package spi_queued_cu_pkg SHALL hold the FSM state enum, register index constants and control bit positions.
REQ-033 Queue SHALL be sub-module spi_transfer_queue (synchronous FIFO, level output); register decode SHALL be inline.

Verification
REQ-034 Reset release -> reg0 reads 0x0000_00E0, reg2 reads 1, ready=1, status 0.
REQ-035 Push beats 0x11,0x22,0x33 back-to-back, transfer_done 4 cycles after each start -> three starts, spi_data_out[0]=0x11,0x22,0x33 in order, reg4=3.
REQ-036 Push QUEUE_DEPTH beats with FSM held in WAIT_DONE -> ready=0, status[23:16]=QUEUE_DEPTH, next beat not accepted.
REQ-037 Bus trigger and stream beat same IDLE cycle -> bus transfer first with register words, queued word transferred after transfer_done.
REQ-038 Bus trigger during WAIT_DONE -> no start, status[1]=1; write 0x2 to reg3 -> status[1]=0.
REQ-039 Reset asserted in WAIT_DONE with 2 entries queued -> outputs defaults immediately, level 0, reg4 unchanged from 0.
